// File: rtl/fft_pkg.sv
// Shared constants, controller state type and stage-offset helper for the
// 16-point radix-2 SDF FFT sequencer.
package fft_pkg;

  localparam int LOG2N = 4;
  localparam int N     = 2 ** LOG2N;
  localparam int TWW   = LOG2N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  // Number of advances before stage s sees the first sample of a frame.
  function automatic int stage_offset(input int s);
    return N - (N >> s);
  endfunction

endpackage

// File: rtl/fft_sdf_ctrl_if.sv
// Sample-stream handshake, stage selects and output tags of the SDF sequencer.
interface fft_sdf_ctrl_if;
  import fft_pkg::*;

  logic                  clear;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic                  adv;
  logic                  zero_ins;
  logic [LOG2N-1:0]      bf_en;
  logic [LOG2N*TWW-1:0]  tw_idx;
  logic                  out_valid;
  logic                  out_first;
  logic                  out_last;
  logic [LOG2N-1:0]      out_index;
  logic                  busy;
  logic                  err_align;

  // Stream source / system side.
  modport master (
    output clear, in_valid, in_last,
    input  in_ready, adv, zero_ins, bf_en, tw_idx,
    input  out_valid, out_first, out_last, out_index, busy, err_align
  );

  // Controller side.
  modport slave (
    input  clear, in_valid, in_last,
    output in_ready, adv, zero_ins, bf_en, tw_idx,
    output out_valid, out_first, out_last, out_index, busy, err_align
  );

endinterface

// File: rtl/fft_stage_decode.sv
// Per-stage butterfly/bypass select and twiddle index, decoded from the
// global sample counter shifted by this stage's pipeline offset.
module fft_stage_decode
  import fft_pkg::*;
#(
  parameter int STAGE = 0
) (
  input  logic [LOG2N-1:0] s_cnt,
  output logic             bf_en,
  output logic [TWW-1:0]   tw_idx
);

  // Only the low LOG2N-STAGE bits of the in-frame position matter here: the
  // top one selects butterfly mode, the rest index within the half-span.
  localparam int              JW     = LOG2N - STAGE;
  localparam logic [LOG2N-1:0] OFFSET = LOG2N'(stage_offset(STAGE));

  logic [JW-1:0] j;

  assign j     = JW'(s_cnt - OFFSET);
  assign bf_en = j[JW-1];
  // With the top bit clear, j already equals j mod D_s.
  assign tw_idx = bf_en ? '0 : (TWW'(j) << STAGE);

endmodule

// File: rtl/fft_sdf_ctrl.sv
// Sequencer for the 16-point SDF FFT: accepts the sample stream, issues the
// global advance strobe, drains the pipe after the last frame and tags the
// results with valid/first/last/index.
module fft_sdf_ctrl
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  fft_sdf_ctrl_if.slave    bus
);

  localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] FL_LAST = LOG2N'(N - 2);

  ctrl_state_t      state_q, state_d;
  logic [LOG2N-1:0] s_cnt_q, s_cnt_d;
  logic [LOG2N-1:0] fill_q, fill_d;
  logic [LOG2N-1:0] fl_cnt_q, fl_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;
  logic [LOG2N-1:0] out_index_q, out_index_d;
  logic             err_align_q, err_align_d;

  logic             in_ready;
  logic             accept;
  logic             adv;
  logic [LOG2N-1:0] s_cnt_inc;
  logic [LOG2N-1:0] bf_en_w;
  logic [TWW-1:0]   tw_idx_w [LOG2N];

  assign in_ready  = (state_q != FLUSH) && !bus.clear;
  assign accept    = bus.in_valid && in_ready;
  assign adv       = accept || ((state_q == FLUSH) && !bus.clear);
  assign s_cnt_inc = s_cnt_q + 1'b1;

  // Next state, counters and output tags; clear wins, no advance means hold.
  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    fill_d      = fill_q;
    fl_cnt_d    = fl_cnt_q;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    out_index_d = out_index_q;
    err_align_d = 1'b0;

    if (bus.clear) begin
      state_d     = IDLE;
      s_cnt_d     = '0;
      fill_d      = '0;
      fl_cnt_d    = '0;
      out_index_d = '0;
    end else if (adv) begin
      s_cnt_d     = s_cnt_inc;
      fill_d      = (fill_q == CNT_MAX) ? fill_q : fill_q + 1'b1;
      err_align_d = accept && bus.in_last && (s_cnt_q != CNT_MAX);
      // The pipe holds a finished result once N-1 advances have happened.
      if (fill_q == CNT_MAX) begin
        out_valid_d = 1'b1;
        out_index_d = s_cnt_inc;
        out_first_d = (s_cnt_inc == '0);
        out_last_d  = (s_cnt_inc == CNT_MAX);
      end
      case (state_q)
        IDLE:  state_d = RUN;
        RUN:   if (bus.in_last && (s_cnt_q == CNT_MAX)) state_d = FLUSH;
        FLUSH: begin
          if (fl_cnt_q == FL_LAST) begin
            state_d  = IDLE;
            s_cnt_d  = '0;
            fill_d   = '0;
            fl_cnt_d = '0;
          end else begin
            fl_cnt_d = fl_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and tag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      fill_q      <= '0;
      fl_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      err_align_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      fill_q      <= fill_d;
      fl_cnt_q    <= fl_cnt_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
      err_align_q <= err_align_d;
    end
  end

  for (genvar gi = 0; gi < LOG2N; gi++) begin : g_stage
    fft_stage_decode #(.STAGE(gi)) u_dec (
      .s_cnt  (s_cnt_q),
      .bf_en  (bf_en_w[gi]),
      .tw_idx (tw_idx_w[gi])
    );
    assign bus.tw_idx[gi*TWW +: TWW] = tw_idx_w[gi];
  end

  assign bus.bf_en     = bf_en_w;
  assign bus.in_ready  = in_ready;
  assign bus.adv       = adv;
  assign bus.zero_ins  = (state_q == FLUSH);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_index = out_index_q;
  assign bus.err_align = err_align_q;

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Randomised scoreboard bench for the SDF FFT sequencer. The reference model
// counts advances per run and derives every expected value from that count.
module tb_fft_sdf_ctrl;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_sdf_ctrl_if bus ();

  fft_sdf_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cycle;
    int idx;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: phase 0 idle, 1 running, 2 draining.
  int m_phase = 0;
  int m_cnt   = 0;
  int m_fl    = 0;
  bit exp_err  = 1'b0;
  bit exp_busy = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every tagged output must match the oldest scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid) begin
        n_out++;
        $display("OUT cyc=%0d idx=%0d first=%0b last=%0b",
                 cyc, bus.out_index, bus.out_first, bus.out_last);
        if (sb_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_cycle", cyc, e.cycle);
          check("out_index", int'(bus.out_index), e.idx);
          check("out_first", int'(bus.out_first), int'(e.idx == 0));
          check("out_last", int'(bus.out_last), int'(e.idx == N - 1));
        end
      end
    end
  end

  // One clock of stimulus: check registered state, drive, check the
  // combinational outputs, then advance the model across the next edge.
  task automatic step(input bit v, input bit last, input bit clr);
    int pos, off, j, d, e_bf, e_tw;
    bit e_rdy, e_adv;
    @(negedge clk);
    check("err_align", int'(bus.err_align), int'(exp_err));
    check("busy", int'(bus.busy), int'(exp_busy));
    bus.in_valid = v;
    bus.in_last  = last;
    bus.clear    = clr;
    #1;
    pos   = m_cnt % N;
    e_rdy = (m_phase != 2) && !clr;
    e_adv = (v && e_rdy) || (m_phase == 2 && !clr);
    check("in_ready", int'(bus.in_ready), int'(e_rdy));
    check("adv", int'(bus.adv), int'(e_adv));
    check("zero_ins", int'(bus.zero_ins), int'(m_phase == 2));
    for (int s = 0; s < LOG2N; s++) begin
      off  = N - N / (2 ** s);
      j    = ((pos - off) % N + N) % N;
      d    = N / (2 ** (s + 1));
      e_bf = ((j % (2 * d)) >= d) ? 1 : 0;
      e_tw = e_bf ? 0 : (j % d) * (2 ** s);
      check($sformatf("bf_en%0d", s), int'(bus.bf_en[s]), e_bf);
      check($sformatf("tw_idx%0d", s), int'(bus.tw_idx[s*TWW +: TWW]), e_tw);
    end
    if (clr) begin
      m_phase = 0; m_cnt = 0; m_fl = 0; exp_err = 1'b0;
    end else if (e_adv) begin
      if (m_cnt >= N - 1) sb_q.push_back('{cycle: cyc + 1, idx: (m_cnt - (N - 1)) % N});
      exp_err = v && e_rdy && last && (pos != N - 1);
      m_cnt++;
      case (m_phase)
        0: m_phase = 1;
        1: if (v && last && pos == N - 1) m_phase = 2;
        default: begin
          m_fl++;
          if (m_fl == N - 1) begin
            m_phase = 0; m_cnt = 0; m_fl = 0;
          end
        end
      endcase
    end else begin
      exp_err = 1'b0;
    end
    exp_busy = (m_phase != 0);
  endtask

  // Send nsamp samples, in_last on the final one and optionally on mis_at.
  // gap_mode: 0 continuous, 1 alternate idle cycles, 2 random idle cycles.
  task automatic send(input int nsamp, input int gap_mode, input int mis_at);
    for (int i = 0; i < nsamp; i++) begin
      if (gap_mode == 1 && i > 0) step(1'b0, 1'b0, 1'b0);
      if (gap_mode == 2) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) step(1'b0, 1'b1, 1'b0);
      end
      step(1'b1, (i == nsamp - 1) || (i == mis_at), 1'b0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && m_phase != 0; k++) step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("sb_empty_after_drain", sb_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_out_first"}, int'(bus.out_first), 0);
    check({tag, "_out_last"}, int'(bus.out_last), 0);
    check({tag, "_out_index"}, int'(bus.out_index), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_err_align"}, int'(bus.err_align), 0);
    check({tag, "_bf_en"}, int'(bus.bf_en), 0);
    check({tag, "_tw_idx"}, int'(bus.tw_idx), 0);
    check({tag, "_in_ready"}, int'(bus.in_ready), 1);
    check({tag, "_zero_ins"}, int'(bus.zero_ins), 0);
  endtask

  // Pull rst low between edges and release it on a later negedge.
  task automatic async_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.clear    = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    m_phase = 0; m_cnt = 0; m_fl = 0;
    exp_err = 1'b0; exp_busy = 1'b0;
    sb_q.delete();
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int base;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.clear    = 1'b0;
    #3 check_reset_outputs("reset");
    @(negedge clk);
    #1 rst = 1'b1;

    // Single continuous frame.
    base = n_out;
    send(N, 0, -1);
    drain();
    check("frame1_out_count", n_out - base, N);

    // Three back-to-back frames, one in_last at the very end.
    base = n_out;
    send(3 * N, 0, -1);
    drain();
    check("frame3_out_count", n_out - base, 3 * N);

    // Alternating valid through one frame.
    base = n_out;
    send(N, 1, -1);
    drain();
    check("toggle_out_count", n_out - base, N);

    // Misaligned in_last on sample 5, aligned one on sample 15.
    base = n_out;
    send(N, 0, 5);
    drain();
    check("misalign_out_count", n_out - base, N);

    // Clear at flush advance 7 with in_valid high, then a clean frame.
    send(N, 0, -1);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("after_clear_out_valid", int'(bus.out_valid), 0);
    base = n_out;
    send(N, 0, -1);
    drain();
    check("post_clear_out_count", n_out - base, N);

    // Asynchronous reset mid-run, after outputs have started.
    send(N + 4, 0, N + 10);
    async_reset();
    base = n_out;
    send(N, 0, -1);
    drain();
    check("post_rst_out_count", n_out - base, N);

    // Randomised frames, gaps and misaligned lasts.
    for (int t = 0; t < 8; t++) begin
      int nf, mis;
      nf  = N * $urandom_range(1, 3);
      mis = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 2)) : -1;
      send(nf, $urandom_range(0, 2), mis);
      drain();
    end

    check("final_sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
